// File: rtl/alu_cmd_sequencer.sv
// Transaction front end for the combinational 16-bit ALU. It accepts one accumulator command at a time,
// runs it through the ALU or a local path, and returns the accumulator over a valid/ready response.
module alu_cmd_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_operand,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_neg,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    output logic [CNT_W-1:0] cmd_count
);

    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_LOAD  = 3'b101;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_ctrl_q, alu_ctrl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             zero_q, neg_q;

    // Next-state and datapath update; the operand/op registers double as the ALU B/control drivers.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        alu_b_d    = alu_b_q;
        alu_ctrl_d = alu_ctrl_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    if (cmd_op <= OP_XOR) begin
                        alu_b_d    = cmd_operand;
                        alu_ctrl_d = cmd_op;
                        state_d    = ST_ISSUE;
                    end else begin
                        // Local ops finish in the accept edge; READ leaves acc untouched.
                        if (cmd_op == OP_LOAD) begin
                            acc_d = cmd_operand;
                        end else if (cmd_op == OP_CLEAR) begin
                            acc_d = '0;
                        end
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                acc_d   = alu_result;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            alu_b_q     <= '0;
            alu_ctrl_q  <= 3'b000;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            zero_q      <= 1'b1;
            neg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            alu_b_q     <= alu_b_d;
            alu_ctrl_q  <= alu_ctrl_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            zero_q      <= (acc_d == '0);
            neg_q       <= acc_d[WIDTH-1];
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = acc_q;
    assign rsp_zero    = zero_q;
    assign rsp_neg     = neg_q;
    assign alu_a       = acc_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_ctrl_q;
    assign cmd_count   = cnt_q;

endmodule
